// File: rtl/seg7_bcd_driver_if.sv
// Conversion handshake between a binary value source and seg7_bcd_driver.
// The source side is the master; the driver is the slave.
interface seg7_bcd_driver_if;
    logic [15:0] value_in;
    logic        start;
    logic        busy;
    logic        ready;
    logic [15:0] bcd;
    logic        overflow;

    modport master (output value_in, start, input  busy, ready, bcd, overflow);
    modport slave  (input  value_in, start, output busy, ready, bcd, overflow);
endinterface

// File: rtl/seg7_bcd_driver.sv
// Sequential double-dabble binary-to-BCD converter (one shift per clock)
// feeding a continuously scanned, common-anode 4-digit 7-segment display.
module seg7_bcd_driver #(
    parameter int SCAN_DIV = 16
) (
    input  logic               CLK,
    input  logic               CLEAR,
    seg7_bcd_driver_if.slave   cv,
    output logic [3:0]         anode,
    output logic [6:0]         seg
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state, state_nxt;
    logic [15:0]    sreg;
    logic [19:0]    scratch, scratch_adj;
    logic [4:0]     iter;
    logic [15:0]    bcd_q;
    logic           ovf_q;
    logic           ready_q;
    logic [SW-1:0]  scan_cnt;
    logic [1:0]     idx;
    logic [3:0]     nib;

    // Add-3 correction applied to all five scratch digits in parallel
    for (genvar g = 0; g < 5; g++) begin : g_add3
        assign scratch_adj[4*g +: 4] = (scratch[4*g +: 4] >= 4'd5) ?
                                       scratch[4*g +: 4] + 4'd3 : scratch[4*g +: 4];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cv.start) state_nxt = SHIFT;
            SHIFT:   if (iter == 5'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            state   <= IDLE;
            sreg    <= '0;
            scratch <= '0;
            iter    <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= 1'b0;
            case (state)
                IDLE: if (cv.start) begin
                    sreg    <= cv.value_in;
                    scratch <= '0;
                    iter    <= '0;
                end
                SHIFT: begin
                    scratch <= {scratch_adj[18:0], sreg[15]};
                    sreg    <= {sreg[14:0], 1'b0};
                    iter    <= iter + 5'd1;
                end
                DONE: begin
                    bcd_q   <= scratch[15:0];
                    ovf_q   <= |scratch[19:16];
                    ready_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cv.busy     = (state != IDLE);
    assign cv.ready    = ready_q;
    assign cv.bcd      = bcd_q;
    assign cv.overflow = ovf_q;

    // Display scan is free-running; only CLEAR re-aligns it
    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    assign anode = ~(4'b0001 << idx);
    assign nib   = bcd_q[4*idx +: 4];

    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: tb/tb_seg7_bcd_driver.sv
// Self-checking bench for seg7_bcd_driver: directed scenarios plus random
// conversions checked against a decimal-arithmetic reference model.
module tb_seg7_bcd_driver;
    logic       CLK = 1'b0;
    logic       CLEAR;
    logic [3:0] anode;
    logic [6:0] seg;

    seg7_bcd_driver_if ifc();

    seg7_bcd_driver #(.SCAN_DIV(4)) dut (
        .CLK(CLK), .CLEAR(CLEAR), .cv(ifc.slave), .anode(anode), .seg(seg)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          tb_t  = 0;      // cycles since the last CLEAR edge
    logic [15:0] exp_bcd = '0;
    logic [6:0]  seg_tab [0:9];

    always @(posedge CLK) tb_t <= CLEAR ? 0 : tb_t + 1;

    function automatic logic [15:0] ref_bcd(input int v);
        return 16'(((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 | ((v / 10) % 10) << 4 | (v % 10));
    endfunction

    function automatic logic [3:0] ref_anode();
        int d = (tb_t / 4) % 4;
        return ~(4'(1) << d);
    endfunction

    function automatic logic [6:0] ref_seg();
        int d = (tb_t / 4) % 4;
        int digit = int'((exp_bcd >> (4 * d)) & 16'hF);
        return seg_tab[digit];
    endfunction

    task automatic run_conv(input logic [15:0] v, output int rc, output int bc);
        rc = -1; bc = 0;
        @(negedge CLK); ifc.value_in = v; ifc.start = 1'b1;
        @(negedge CLK); ifc.start = 1'b0;
        if (ifc.busy) bc++;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (ifc.busy) bc++;
            if (ifc.ready) begin rc = k; break; end
        end
    endtask

    task automatic test_reset();
        CLEAR = 1'b1;
        repeat (2) @(negedge CLK);
        CLEAR = 1'b0;
        exp_bcd = '0;
        n_cmp++; if (ifc.busy !== 1'b0)      begin n_mis++; $display("FAIL reset_busy got %b want 0", ifc.busy); end
        n_cmp++; if (ifc.ready !== 1'b0)     begin n_mis++; $display("FAIL reset_ready got %b want 0", ifc.ready); end
        n_cmp++; if (ifc.bcd !== 16'h0000)   begin n_mis++; $display("FAIL reset_bcd got %h want 0000", ifc.bcd); end
        n_cmp++; if (ifc.overflow !== 1'b0)  begin n_mis++; $display("FAIL reset_ovf got %b want 0", ifc.overflow); end
        n_cmp++; if (anode !== 4'b1110)      begin n_mis++; $display("FAIL reset_anode got %b want 1110", anode); end
        n_cmp++; if (seg !== 7'b1000000)     begin n_mis++; $display("FAIL reset_seg got %b want 1000000", seg); end
    endtask

    task automatic test_basic();
        int rc, bc;
        run_conv(16'd1234, rc, bc);
        exp_bcd = 16'h1234;
        n_cmp++; if (rc !== 17)              begin n_mis++; $display("FAIL basic_ready_lat got %0d want 17", rc); end
        n_cmp++; if (bc !== 17)              begin n_mis++; $display("FAIL basic_busy_len got %0d want 17", bc); end
        n_cmp++; if (ifc.bcd !== 16'h1234)   begin n_mis++; $display("FAIL basic_bcd got %h want 1234", ifc.bcd); end
        n_cmp++; if (ifc.overflow !== 1'b0)  begin n_mis++; $display("FAIL basic_ovf got %b want 0", ifc.overflow); end
        @(negedge CLK);
        n_cmp++; if (ifc.ready !== 1'b0)     begin n_mis++; $display("FAIL basic_ready_pulse got %b want 0", ifc.ready); end
    endtask

    task automatic test_back_to_back();
        int r1 = -1, r2 = -1;
        @(negedge CLK); ifc.value_in = 16'd65535; ifc.start = 1'b1;
        @(negedge CLK); ifc.value_in = 16'd9999;
        for (int k = 1; k <= 45; k++) begin
            @(negedge CLK);
            if (k == 18) ifc.start = 1'b0;
            if (ifc.ready) begin
                if (r1 < 0) begin
                    r1 = k;
                    n_cmp++; if (ifc.bcd !== 16'h5535)  begin n_mis++; $display("FAIL ovf_bcd got %h want 5535", ifc.bcd); end
                    n_cmp++; if (ifc.overflow !== 1'b1) begin n_mis++; $display("FAIL ovf_flag got %b want 1", ifc.overflow); end
                end else if (r2 < 0) begin
                    r2 = k;
                    n_cmp++; if (ifc.bcd !== 16'h9999)  begin n_mis++; $display("FAIL b2b_bcd got %h want 9999", ifc.bcd); end
                    n_cmp++; if (ifc.overflow !== 1'b0) begin n_mis++; $display("FAIL b2b_ovf got %b want 0", ifc.overflow); end
                end
            end
        end
        exp_bcd = 16'h9999;
        n_cmp++; if (r1 !== 17) begin n_mis++; $display("FAIL b2b_first_ready got %0d want 17", r1); end
        n_cmp++; if (r2 !== 35) begin n_mis++; $display("FAIL b2b_second_ready got %0d want 35", r2); end
    endtask

    task automatic test_ignored_start();
        int nrdy = 0;
        logic [15:0] got = 'x;
        @(negedge CLK); ifc.value_in = 16'd42; ifc.start = 1'b1;
        @(negedge CLK); ifc.start = 1'b0;
        repeat (4) @(negedge CLK);
        ifc.value_in = 16'd7; ifc.start = 1'b1;
        @(negedge CLK); ifc.start = 1'b0;
        for (int k = 0; k < 35; k++) begin
            @(negedge CLK);
            if (ifc.ready) begin nrdy++; got = ifc.bcd; end
        end
        exp_bcd = 16'h0042;
        n_cmp++; if (nrdy !== 1)        begin n_mis++; $display("FAIL ign_ready_count got %0d want 1", nrdy); end
        n_cmp++; if (got !== 16'h0042)  begin n_mis++; $display("FAIL ign_bcd got %h want 0042", got); end
        n_cmp++; if (ifc.busy !== 1'b0) begin n_mis++; $display("FAIL ign_busy_after got %b want 0", ifc.busy); end
    endtask

    task automatic test_scan();
        int rc, bc, bad = 0;
        run_conv(16'd1234, rc, bc);
        exp_bcd = ref_bcd(1234);
        for (int k = 0; k < 32; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (anode !== ref_anode() || seg !== ref_seg()) begin
                n_mis++; bad++;
                if (bad < 6) $display("FAIL scan t=%0d anode/seg got %b/%b want %b/%b",
                                      tb_t, anode, seg, ref_anode(), ref_seg());
            end
        end
    endtask

    task automatic test_reset_mid();
        int nrdy = 0, rc, bc;
        @(negedge CLK); ifc.value_in = 16'd500; ifc.start = 1'b1;
        @(negedge CLK); ifc.start = 1'b0;
        repeat (7) @(negedge CLK);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        exp_bcd = '0;
        n_cmp++; if (ifc.busy !== 1'b0)    begin n_mis++; $display("FAIL mid_busy got %b want 0", ifc.busy); end
        n_cmp++; if (ifc.bcd !== 16'h0000) begin n_mis++; $display("FAIL mid_bcd got %h want 0000", ifc.bcd); end
        for (int k = 0; k < 25; k++) begin
            @(negedge CLK);
            if (ifc.ready) nrdy++;
        end
        n_cmp++; if (nrdy !== 0) begin n_mis++; $display("FAIL mid_no_ready got %0d want 0", nrdy); end
        run_conv(16'd0, rc, bc);
        n_cmp++; if (rc !== 17)            begin n_mis++; $display("FAIL mid_zero_ready got %0d want 17", rc); end
        n_cmp++; if (ifc.bcd !== 16'h0000) begin n_mis++; $display("FAIL mid_zero_bcd got %h want 0000", ifc.bcd); end
    endtask

    task automatic test_random();
        int rc, bc, v;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0: v = 9999;
                1: v = 10000;
                2: v = 0;
                default: v = int'($urandom_range(0, 65535));
            endcase
            run_conv(16'(v), rc, bc);
            exp_bcd = ref_bcd(v);
            n_cmp++; if (rc !== 17) begin n_mis++; $display("FAIL rnd_lat v=%0d got %0d want 17", v, rc); end
            n_cmp++; if (ifc.bcd !== exp_bcd) begin n_mis++; $display("FAIL rnd_bcd v=%0d got %h want %h", v, ifc.bcd, exp_bcd); end
            n_cmp++; if (ifc.overflow !== (v > 9999)) begin n_mis++; $display("FAIL rnd_ovf v=%0d got %b want %b", v, ifc.overflow, v > 9999); end
            repeat (i % 5) @(negedge CLK);
            n_cmp++; if (seg !== ref_seg() || anode !== ref_anode()) begin
                n_mis++; $display("FAIL rnd_disp v=%0d got %b/%b want %b/%b", v, anode, seg, ref_anode(), ref_seg());
            end
        end
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        CLEAR = 1'b1; ifc.start = 1'b0; ifc.value_in = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignored_start();
        test_scan();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
